// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
//
// Purpose : Shared types and constants for the sprite blitter slice.
//           - blit_state_t : blitter FSM states
//           - SCREEN_W/H   : frame-buffer geometry
//           - TRANSPARENT  : palette index that is never written
//           - pix_t        : palette-index pixel type
//           - fb_offset()  : row-major frame-buffer address of a screen pixel
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int TRANSPARENT = 0;
    localparam int FB_AW       = 19;

    typedef logic [4:0] pix_t;

    // The screen width is a constant, so the product reduces to a shift-add.
    // Only on-screen coordinates are ever written, so the result always fits.
    function automatic logic [FB_AW-1:0] fb_offset(input logic [10:0] sx,
                                                   input logic [10:0] sy);
        logic [FB_AW-1:0] y_ext;
        logic [FB_AW-1:0] x_ext;
        y_ext = FB_AW'(sy);
        x_ext = FB_AW'(sx);
        return (y_ext * FB_AW'(SCREEN_W)) + x_ext;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// sprite_addr_gen
//
// Purpose : Row/column counters and the running sprite-ROM read address.
//           The address is advanced incrementally; there is no multiplier.
//           With i_hflip latched at load, each row is read right-to-left.
//
// Ports
//   i_clk        in   clock, rising edge
//   i_rst        in   synchronous active-high reset
//   i_load       in   restart at pixel (0,0) of the frame at i_base
//   i_step       in   advance to the next pixel in row-major order
//   i_hflip      in   mirror columns (sampled with i_load)
//   i_base       in   ROM address of pixel (0,0)
//   o_rom_addr   out  current ROM read address (registered)
//   o_row        out  current sprite row
//   o_col        out  current sprite column (screen-side, never mirrored)
//   o_last_pixel out  current pixel is (SPRITE_H-1, SPRITE_W-1)
// -----------------------------------------------------------------------------
module sprite_addr_gen #(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 60,
    parameter int AW       = 19,
    parameter int CW       = $clog2(SPRITE_W),
    parameter int RW       = $clog2(SPRITE_H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic          i_hflip,
    input  logic [AW-1:0] i_base,
    output logic [AW-1:0] o_rom_addr,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last_pixel
);

    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW-1:0] ROW_STEP = AW'(SPRITE_W);
    localparam logic [AW-1:0] FLIP_OFS = AW'(SPRITE_W - 1);

    logic          r_hflip;
    logic [AW-1:0] r_row_base;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] w_next_row_base;

    assign w_next_row_base = r_row_base + ROW_STEP;

    // r_row_base tracks the ROM address of column 0 of the current row, so a
    // mirrored row can start at its right end without re-deriving r*SPRITE_W.
    // NOTE: every register in a clocked block uses <= so all of them update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hflip    <= 1'b0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if (i_load) begin
            r_hflip    <= i_hflip;
            r_row_base <= i_base;
            r_addr     <= i_hflip ? (i_base + FLIP_OFS) : i_base;
            r_col      <= '0;
            r_row      <= '0;
        end else if (i_step) begin
            if (r_col == COL_LAST) begin
                r_col      <= '0;
                r_row      <= r_row + ROW_ONE;
                r_row_base <= w_next_row_base;
                r_addr     <= r_hflip ? (w_next_row_base + FLIP_OFS)
                                      : w_next_row_base;
            end else begin
                r_col  <= r_col + COL_ONE;
                r_addr <= r_hflip ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
            end
        end
    end

    assign o_rom_addr   = r_addr;
    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_last_pixel = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//
// Purpose : Copies one sprite from the sprite ROM (synchronous, 1-cycle read)
//           into the frame-buffer write port, one pixel per cycle, dropping
//           transparent and off-screen pixels.
//
// Optional feature (macro SPRITE_BLITTER_HFLIP_EN):
//           adds input hflip, latched with start; mirrors the sprite
//           horizontally. Without the macro the port is absent and the
//           sprite is never mirrored.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   start      in   blit request, accepted only in IDLE
//   pos_x      in   screen column of sprite left edge
//   pos_y      in   screen row of sprite top edge
//   base_addr  in   ROM address of pixel (0,0) of the animation frame
//   hflip      in   horizontal mirror (only with SPRITE_BLITTER_HFLIP_EN)
//   rom_addr   out  ROM read address
//   rom_data   in   ROM data, valid one cycle after rom_addr
//   fb_we      out  frame-buffer write enable
//   fb_addr    out  frame-buffer write address
//   fb_data    out  frame-buffer write data
//   busy       out  blit in progress
//   done       out  one-cycle completion pulse
//
// Timing (start sampled at edge E0, N = SPRITE_W*SPRITE_H):
//   rom_addr for pixel k is presented after E(k); its write slot appears after
//   E(k+2); done is high after E(N+2), when busy falls.
// -----------------------------------------------------------------------------
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 60,
    parameter int PIX_W    = 5,
    parameter int AW       = 19
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [AW-1:0]    base_addr,
`ifdef SPRITE_BLITTER_HFLIP_EN
    input  logic             hflip,
`endif
    output logic [AW-1:0]    rom_addr,
    input  logic [PIX_W-1:0] rom_data,
    output logic             fb_we,
    output logic [AW-1:0]    fb_addr,
    output logic [PIX_W-1:0] fb_data,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [PIX_W-1:0] TRANSPARENT_PIX = PIX_W'(TRANSPARENT);
    localparam logic [10:0]      SCREEN_W_11     = 11'(SCREEN_W);
    localparam logic [10:0]      SCREEN_H_11     = 11'(SCREEN_H);

    // ---------------------------------------------------------------- control
    blit_state_t r_state;
    logic        r_busy;
    logic        r_done;
    logic [9:0]  r_pos_x;
    logic [9:0]  r_pos_y;

    logic          w_load;
    logic          w_step;
    logic          w_hflip;
    logic          w_last_pixel;
    logic [AW-1:0] w_rom_addr;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;

`ifdef SPRITE_BLITTER_HFLIP_EN
    assign w_hflip = hflip;
`else
    assign w_hflip = 1'b0;
`endif

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == RUN) && !w_last_pixel;

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .AW       (AW),
        .CW       (CW),
        .RW       (RW)
    ) u_addr_gen (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_hflip      (w_hflip),
        .i_base       (base_addr),
        .o_rom_addr   (w_rom_addr),
        .o_row        (w_row),
        .o_col        (w_col),
        .o_last_pixel (w_last_pixel)
    );

    // busy/done are registered from the state, so they lag it by one edge:
    // busy stays high through the DONE state (covering the last write) and
    // done pulses on the edge that leaves DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pos_x <= '0;
            r_pos_y <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pos_x <= pos_x;
                        r_pos_y <= pos_y;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_last_pixel) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- pipeline
    // Screen coordinates are 11 bits wide so a sprite hanging past the right
    // or bottom edge is clipped instead of wrapping to column/row 0.
    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic        w_on_screen;

    assign w_sx        = {1'b0, r_pos_x} + 11'(w_col);
    assign w_sy        = {1'b0, r_pos_y} + 11'(w_row);
    assign w_on_screen = (w_sx < SCREEN_W_11) && (w_sy < SCREEN_H_11);

    // Stage 1 lines up with rom_data: it holds the coordinates of the address
    // the ROM sampled on the same edge. Clipping is folded into its valid bit.
    logic              r_s1_valid;
    logic [10:0]       r_s1_sx;
    logic [10:0]       r_s1_sy;
    logic              r_fb_we;
    logic [AW-1:0]     r_fb_addr;
    logic [PIX_W-1:0]  r_fb_data;

    // NOTE: the datapath registers are reset too, because every output must
    // read 0 in reset and a reset mid-blit must kill any write in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sx    <= '0;
            r_s1_sy    <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
        end else begin
            r_s1_valid <= (r_state == RUN) && w_on_screen;
            r_s1_sx    <= w_sx;
            r_s1_sy    <= w_sy;
            r_fb_we    <= r_s1_valid && (rom_data != TRANSPARENT_PIX);
            r_fb_addr  <= AW'(fb_offset(r_s1_sx, r_s1_sy));
            r_fb_data  <= rom_data;
        end
    end

    assign rom_addr = w_rom_addr;
    assign fb_we    = r_fb_we;
    assign fb_addr  = r_fb_addr;
    assign fb_data  = r_fb_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
